// File: rtl/unary_stream_generator.sv
// -----------------------------------------------------------------------------
// unary_stream_generator
//
// Turns each binary word V (from greycode_decoder.binary_out) into a
// thermometer-coded frame of N = 2^WIDTH bits, one bit per output beat.
// Bit i of a frame is (i < V). So V ones are followed by N-V zeros, and the
// final bit (index N-1) is always 0.
//
// A one-entry holding register lets the next word be accepted while the
// current frame streams. The next frame therefore starts on the cycle right
// after the final beat of the current one.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_value   in   WIDTH-bit binary word V
//   in_valid   in   in_value is valid
//   in_ready   out  a word can be accepted (holding register empty)
//   bit_out    out  current unary bit
//   bit_valid  out  bit_out is valid (a frame is active)
//   bit_ready  in   downstream accepts the current bit
//   bit_last   out  current bit is the final bit of its frame
//   busy       out  a frame is active or a word is waiting
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module unary_stream_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] act_val_q,   act_val_d;
    logic [WIDTH-1:0] pos_q,       pos_d;
    logic [WIDTH-1:0] pend_val_q,  pend_val_d;
    logic             pend_full_q, pend_full_d;

    logic emitting;
    logic at_last;
    logic accept;
    logic beat;

    // Every output is decoded from registers only. Neither in_valid nor
    // bit_ready reaches an output combinationally.
    assign emitting  = (state_q == EMIT);
    assign at_last   = (pos_q == POS_MAX);
    assign in_ready  = !pend_full_q;
    assign bit_valid = emitting;
    assign bit_out   = emitting && (pos_q < act_val_q);
    assign bit_last  = emitting && at_last;
    assign busy      = emitting || pend_full_q;

    assign accept = in_valid && in_ready;
    assign beat   = bit_valid && bit_ready;

    always_comb begin
        state_d     = state_q;
        act_val_d   = act_val_q;
        pos_d       = pos_q;
        pend_val_d  = pend_val_q;
        pend_full_d = pend_full_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    act_val_d = in_value;
                    pos_d     = '0;
                    state_d   = EMIT;
                end
            end

            EMIT: begin
                if (beat && at_last) begin
                    // Final beat. pos wraps to 0 for the next frame. A queued
                    // word wins. Otherwise a word offered on this same edge
                    // goes straight into the active slot.
                    // in_ready is low whenever pend_full_q is set, so the
                    // first two branches can never both apply.
                    pos_d = '0;
                    if (pend_full_q) begin
                        act_val_d   = pend_val_q;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        act_val_d = in_value;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        pos_d = pos_q + POS_ONE;
                    end
                    // Input accepts continue during stalls while the holding
                    // register is empty.
                    if (accept) begin
                        pend_val_d  = in_value;
                        pend_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_val_q   <= '0;
            pos_q       <= '0;
            pend_val_q  <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_val_q   <= act_val_d;
            pos_q       <= pos_d;
            pend_val_q  <= pend_val_d;
            pend_full_q <= pend_full_d;
        end
    end

endmodule

// File: tb/tb_unary_stream_generator.sv
// -----------------------------------------------------------------------------
// tb_unary_stream_generator
//
// Reference model: a queue of words whose frames have not yet finished, plus
// the bit index within the front word's frame. The expected outputs follow
// from that state:
//   valid = queue non-empty
//   bit   = index < front
//   last  = index == N-1
//   busy  = queue non-empty
//   ready = fewer than two outstanding words
//
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_unary_stream_generator;

    localparam int WIDTH = 8;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_value;
    logic             in_valid;
    logic             in_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_last;
    logic             busy;

    always #5 clk = ~clk;

    unary_stream_generator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_last  (bit_last),
        .busy      (busy)
    );

    int checks = 0;
    int passed = 0;

    // Model state
    int q[$];
    int idx = 0;
    int frame_ones = 0;
    int last_frame_ones = 0;
    int frames_done = 0;
    bit last_acc = 0;

    typedef struct {
        logic [7:0] value;
        bit         rand_ready;
        int         exp_ones;
        int         exp_cycles;   // cycles from offer to final beat; 0 = not checked
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    endtask

    // Check the outputs against the model, drive one cycle of inputs,
    // advance the model, then wait for the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] val, input logic rdy);
        logic ev, eo, el;
        bit   beat, acc;
        ev = (q.size() > 0);
        eo = ev ? (idx < q[0]) : 1'b0;
        el = ev && (idx == N - 1);
        chk("bit_valid", bit_valid, ev);
        chk("bit_out",   bit_out,   eo);
        chk("bit_last",  bit_last,  el);
        chk("busy",      busy,      ev);
        chk("in_ready",  in_ready,  (q.size() < 2));
        in_valid  = v;
        in_value  = val;
        bit_ready = rdy;
        beat = ev && rdy;
        acc  = v && (q.size() < 2);
        last_acc = acc;
        if (beat) begin
            if (bit_out === 1'b1) frame_ones++;
            if (idx == N - 1) begin
                chk("frame_ones", frame_ones, q[0]);
                last_frame_ones = frame_ones;
                frame_ones = 0;
                void'(q.pop_front());
                idx = 0;
                frames_done++;
            end else begin
                idx++;
            end
        end
        if (acc) q.push_back(int'(val));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && q.size() > 0; n++) cycle(1'b0, 8'd0, 1'b1);
        chk("drained_idle", busy, 1'b0);
    endtask

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    int f0, fd, cyc, gsend, gi, gexp;
    int gq[$];
    bit sent;
    logic [7:0] gb;

    initial begin
        vecs[0] = '{8'd0,   1'b0, 0,   N + 1};
        vecs[1] = '{8'd255, 1'b0, 255, N + 1};
        vecs[2] = '{8'd5,   1'b1, 5,   0};
        vecs[3] = '{8'd128, 1'b1, 128, 0};
        vecs[4] = '{8'd1,   1'b0, 1,   N + 1};

        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; bit_ready = 1'b0;
        #1;
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_bit_out",   bit_out,   1'b0);
        chk("rst_bit_last",  bit_last,  1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'd0, 1'b1);

        // Table-driven single frames, started from IDLE
        for (int t = 0; t < 5; t++) begin
            f0 = frames_done;
            cyc = 0;
            cycle(1'b1, vecs[t].value, 1'b1);
            cyc++;
            for (int n = 0; n < 3000 && frames_done == f0; n++) begin
                cycle(1'b0, 8'd0, vecs[t].rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
                cyc++;
            end
            chk("vec_frame_done", frames_done, f0 + 1);
            chk("vec_ones", last_frame_ones, vecs[t].exp_ones);
            if (vecs[t].exp_cycles != 0) chk("vec_cycles", cyc, vecs[t].exp_cycles);
        end
        drain();

        // Back-to-back: 3, then 200 offered until accepted into the holding register
        f0 = frames_done;
        cycle(1'b1, 8'd3, 1'b1);
        sent = 0;
        for (int n = 0; n < 1000 && frames_done < f0 + 2; n++) begin
            fd = frames_done;
            cycle(!sent, 8'd200, 1'b1);
            if (last_acc) begin
                sent = 1;
                chk("b2b_ready_low", in_ready, 1'b0);
            end
            if (frames_done == f0 + 1 && fd == f0) begin
                chk("b2b_first_ones", last_frame_ones, 3);
                chk("b2b_nogap", bit_valid, 1'b1);
            end
        end
        chk("b2b_frames", frames_done, f0 + 2);
        chk("b2b_second_ones", last_frame_ones, 200);
        drain();

        // Same-edge accept on the final beat with the holding register empty
        f0 = frames_done;
        cycle(1'b1, 8'd20, 1'b1);
        for (int n = 0; n < 400 && !(q.size() == 1 && idx == N - 1); n++) cycle(1'b0, 8'd0, 1'b1);
        chk("se_at_last", bit_last, 1'b1);
        chk("se_ready", in_ready, 1'b1);
        cycle(1'b1, 8'd7, 1'b1);
        chk("se_nogap", bit_valid, 1'b1);
        for (int n = 0; n < 400 && frames_done < f0 + 2; n++) cycle(1'b0, 8'd0, 1'b1);
        chk("se_frames", frames_done, f0 + 2);
        chk("se_ones", last_frame_ones, 7);
        drain();

        // Reset on beat 100 of V=150 with a word in the holding register
        cycle(1'b1, 8'd150, 1'b1);
        cycle(1'b1, 8'd9, 1'b1);
        for (int n = 0; n < 400 && idx < 99; n++) cycle(1'b0, 8'd0, 1'b1);
        chk("rmid_bit_before", bit_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_bit_valid", bit_valid, 1'b0);
        chk("rmid_bit_out",   bit_out,   1'b0);
        chk("rmid_busy",      busy,      1'b0);
        chk("rmid_in_ready",  in_ready,  1'b1);
        q.delete(); idx = 0; frame_ones = 0;
        in_valid = 1'b1; in_value = 8'd55;   // must be ignored under reset
        @(negedge clk); @(negedge clk);
        chk("rmid_ignored", busy, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 8'd0, 1'b1);
        f0 = frames_done;
        cycle(1'b1, 8'd1, 1'b1);
        for (int n = 0; n < 400 && frames_done == f0; n++) cycle(1'b0, 8'd0, 1'b1);
        chk("rmid_after_ones", last_frame_ones, 1);
        drain();

        // Grey-coded words decoded to binary, streamed back-to-back
        f0 = frames_done; gsend = 0; gq.delete();
        for (int n = 0; n < 20000 && frames_done < f0 + 32; n++) begin
            gi = gsend * 8;
            gb = g2b(8'(gi ^ (gi >> 1)));
            fd = frames_done;
            cycle(gsend < 32, gb, 1'b1);
            if (last_acc) begin gq.push_back(gi); gsend++; end
            if (frames_done != fd && gq.size() > 0) begin
                gexp = gq.pop_front();
                chk("grey_ones", last_frame_ones, gexp);
            end
        end
        chk("grey_frames", frames_done, f0 + 32);
        drain();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++)
            cycle(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) != 0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/unary_stream_generator.md
# unary_stream_generator

Converts each binary word from the grey-code decoder into a thermometer-coded unary bitstream frame of 2^WIDTH bits. It sits directly downstream of `greycode_decoder` in the decompressor path: it takes the decoder's `binary_out` plus a valid/ready handshake, and emits one bit per beat to the unary consumer. A one-entry holding register lets the next word be accepted while the current frame streams, so back-to-back frames have no bubble.

## Interface
- `WIDTH`, default 8: word width. Frame length is N = 2^WIDTH bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_value`  in  WIDTH  binary word V, connected to `greycode_decoder.binary_out`.
- `in_valid`  in  1  `in_value` is valid.
- `in_ready`  out  1  block can accept a word; equals `!pend_full`.
- `bit_out`  out  1  current unary bit.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  downstream accepts the bit.
- `bit_last`  out  1  marks the final bit (index N-1) of a frame.
- `busy`  out  1  a frame is active or a word is pending.

## Operation
- Input handshake: a word is accepted on a rising edge where `in_valid && in_ready` and `rst_n` is high.
- Output handshake: a beat transfers on a rising edge where `bit_valid && bit_ready`.
- Registers:
  - `act_val` (WIDTH): value of the active frame.
  - `pos` (WIDTH): index of the current bit within the frame.
  - `pend_val` / `pend_full`: one-entry holding register.
  - `state`: IDLE or EMIT.
- Bit rule: `bit_out = (pos < act_val)`, an unsigned WIDTH-bit compare.
  - V=0 gives N zeros.
  - V=2^WIDTH-1 gives N-1 ones followed by a single 0.
  - Bit N-1 is always 0.
- `bit_last = (state==EMIT) && (pos == all ones)`.
- IDLE:
  - Outputs: `bit_valid`=0, `bit_out`=0, `bit_last`=0.
  - On accept: `act_val`←V, `pos`←0, go to EMIT. `pend_full` is untouched.
- EMIT:
  - Outputs: `bit_valid`=1.
  - On a beat with `pos` != all ones: `pos`←`pos`+1.
  - An accept with `pend_full`=0 stores V in `pend_val` and sets `pend_full`, unless it coincides with a final beat (see below).
- Final beat (beat with `pos` == all ones): `pos` wraps to 0, and the next state is chosen by priority:
  1. `pend_full`: `act_val`←`pend_val`, clear `pend_full`, stay in EMIT.
  2. Else, accept on the same edge: `act_val`←V directly, stay in EMIT. This bypasses the pending register.
  3. Else: go to IDLE.
- When `pend_full`=1, `in_ready`=0, so an accept and a pending unload never conflict.
- Stall: while `bit_ready`=0, `bit_out`, `bit_last` and `pos` are held stable. Input accepts still proceed while the pending register is empty.
- `busy = (state==EMIT) || pend_full`.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `state`=IDLE; `pos`, `act_val` and `pend_val` = 0; `pend_full`=0.
  - Outputs: `bit_valid`=0, `bit_out`=0, `bit_last`=0, `busy`=0, `in_ready`=1.
  - Input handshakes are ignored while reset is asserted.
- Latency: for a word accepted at edge k, bit 0 is valid in the cycle after edge k.
- With `bit_ready` held high, one frame occupies exactly N cycles.
- Back-to-back frames (pending word present, or same-edge accept at the final beat): bit 0 of the next frame follows the final beat with zero gap cycles.
- Reset mid-frame: the frame and any pending word are discarded; outputs drop asynchronously. After release, the block waits in IDLE for a new accept.
- `in_ready` and `busy` are combinational from registers only. There is no path from `in_valid` or `bit_ready` to any output.

## Test plan
- V=0, `bit_ready`=1 → 256 beats, all 0; `bit_last` only on beat 256; then IDLE, `bit_valid`=0.
- V=255 → beats 1-255 are 1, beat 256 is 0 with `bit_last`=1; ones count 255.
- V=5 with `bit_ready` toggled pseudo-randomly → exactly 5 ones then 251 zeros.
  - `bit_out` stable during stalls.
  - Total transferred beats = 256.
- Back-to-back words 3 and 200, `in_valid` held high:
  - 200 is accepted into the pending register during frame 1, then `in_ready`=0.
  - Frame 2 starts the cycle after frame 1's `bit_last`, with no gap.
  - Frame 2 ones count is 200.
- Same-edge accept at the final beat with the pending register empty (V=7 offered exactly on the `bit_last` beat) → next frame starts immediately with 7 ones.
- Reset asserted on beat 100 of V=150, with a pending word present:
  - Outputs are 0 immediately; `busy`=0.
  - After release, a new V=1 produces exactly 1 one.
- Chained with `greycode_decoder`: for i=0..255, drive `grey_in` = i^(i>>1) → each frame's ones count equals i.
